// File: rtl/bsg_router_traffic_endpoint.sv
// bsg_router_traffic_endpoint
//
// Processor-side client for the P port of a mesh router tile. A transmit FSM
// injects a burst of single-flit packets addressed to a destination tile. The
// receive side sinks every packet ejected to P, counting and XOR-checksumming
// it and flagging any packet whose destination is not this tile.
//
// Optional feature macro: BSG_ROUTER_TRAFFIC_ENDPOINT_RX_STALL_EN
//   When defined, the RX ready is gated by bit 0 of a free-running 16-bit
//   Fibonacci LFSR to exercise router backpressure.
//
// Ports
//   clk_i, reset_i       clock; asynchronous active-high reset
//   link_i               from router P output {v, data, ready_and_rev}
//   link_o               to router P input    {v, data, ready_and_rev}
//   my_x_i, my_y_i       this tile's coordinates
//   start_i              one-cycle burst start pulse
//   dest_x_i, dest_y_i   burst destination, sampled on start
//   num_pkts_i           burst length, sampled on start
//   busy_o, tx_done_o    TX FSM in SEND / DONE
//   rx_count_o           packets received, saturating
//   rx_checksum_o        XOR of received data words
//   rx_err_o             sticky destination-mismatch flag
module bsg_router_traffic_endpoint #(
  parameter int unsigned width_p        = 128,
  parameter int unsigned x_cord_width_p = 5,
  parameter int unsigned y_cord_width_p = 5,
  localparam int unsigned link_sif_width_lp = width_p + 2
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [link_sif_width_lp-1:0] link_i,
  output logic [link_sif_width_lp-1:0] link_o,
  input  logic [x_cord_width_p-1:0]    my_x_i,
  input  logic [y_cord_width_p-1:0]    my_y_i,
  input  logic                         start_i,
  input  logic [x_cord_width_p-1:0]    dest_x_i,
  input  logic [y_cord_width_p-1:0]    dest_y_i,
  input  logic [15:0]                  num_pkts_i,
  output logic                         busy_o,
  output logic                         tx_done_o,
  output logic [31:0]                  rx_count_o,
  output logic [width_p-1:0]           rx_checksum_o,
  output logic                         rx_err_o
);

  typedef enum logic [1:0] {StIdle, StSend, StDone} tx_state_e;

  tx_state_e                 state_q, state_d;
  logic [x_cord_width_p-1:0] dest_x_q, dest_x_d;
  logic [y_cord_width_p-1:0] dest_y_q, dest_y_d;
  logic [15:0]               num_q, num_d;
  logic [15:0]               seq_q, seq_d;
  logic [15:0]               seq_inc;
  logic                      rdy_en_q;
  logic [31:0]               rx_count_q, rx_count_d;
  logic [width_p-1:0]        rx_checksum_q, rx_checksum_d;
  logic                      rx_err_q, rx_err_d;

  logic               tx_v, tx_accept;
  logic [width_p-1:0] tx_payload;
  logic               rx_v, rx_rdy, rx_accept, rx_dest_bad;
  logic [width_p-1:0] rx_data;

  // Link unpacking: {v, data, ready_and_rev}, v is the MSB.
  assign rx_v    = link_i[width_p+1];
  assign rx_data = link_i[width_p:1];

`ifdef BSG_ROUTER_TRAFFIC_ENDPOINT_RX_STALL_EN
  logic [15:0] lfsr_q;

  // Fibonacci LFSR, taps 16,14,13,11; the new bit enters at bit 0.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign rx_rdy = rdy_en_q & lfsr_q[0];
`else
  assign rx_rdy = rdy_en_q;
`endif

  assign tx_v       = (state_q == StSend);
  assign tx_accept  = tx_v & link_i[0];
  assign seq_inc    = seq_q + 16'd1;
  assign tx_payload = width_p'({seq_q, my_y_i, my_x_i, dest_y_q, dest_x_q});

  assign rx_accept   = rx_v & rx_rdy;
  assign rx_dest_bad = (rx_data[x_cord_width_p-1:0] != my_x_i) ||
                       (rx_data[x_cord_width_p+y_cord_width_p-1:x_cord_width_p] != my_y_i);

  always_comb begin
    state_d  = state_q;
    dest_x_d = dest_x_q;
    dest_y_d = dest_y_q;
    num_d    = num_q;
    seq_d    = seq_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          dest_x_d = dest_x_i;
          dest_y_d = dest_y_i;
          num_d    = num_pkts_i;
          seq_d    = '0;
          state_d  = (num_pkts_i != 16'd0) ? StSend : StDone;
        end
      end
      StSend: begin
        if (tx_accept) begin
          seq_d = seq_inc;
          if (seq_inc == num_q) state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rx_count_d    = rx_count_q;
    rx_checksum_d = rx_checksum_q;
    rx_err_d      = rx_err_q;
    if (rx_accept) begin
      if (rx_count_q != 32'hFFFF_FFFF) rx_count_d = rx_count_q + 32'd1;
      rx_checksum_d = rx_checksum_q ^ rx_data;
      rx_err_d      = rx_err_q | rx_dest_bad;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= StIdle;
      dest_x_q      <= '0;
      dest_y_q      <= '0;
      num_q         <= '0;
      seq_q         <= '0;
      rdy_en_q      <= 1'b0;
      rx_count_q    <= '0;
      rx_checksum_q <= '0;
      rx_err_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      dest_x_q      <= dest_x_d;
      dest_y_q      <= dest_y_d;
      num_q         <= num_d;
      seq_q         <= seq_d;
      rdy_en_q      <= 1'b1;
      rx_count_q    <= rx_count_d;
      rx_checksum_q <= rx_checksum_d;
      rx_err_q      <= rx_err_d;
    end
  end

  // Data is forced to zero whenever v is low so the idle link reads as all-zero.
  assign link_o        = {tx_v, (tx_v ? tx_payload : '0), rx_rdy};
  assign busy_o        = tx_v;
  assign tx_done_o     = (state_q == StDone);
  assign rx_count_o    = rx_count_q;
  assign rx_checksum_o = rx_checksum_q;
  assign rx_err_o      = rx_err_q;

endmodule
